// File: rtl/timer_counter.sv
// timer_counter: register-mapped down-counter with one-shot / auto-reload modes and a maskable irq.
// Define TIMER_COUNTER_PRESCALE_EN to add the 8-bit tick prescaler at addr 3.
module timer_counter #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] datain,
    output logic [31:0] dataout,
    output logic        irq,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PRESET   = 2'd1;
    localparam logic [1:0] ADDR_COUNT    = 2'd2;
    localparam logic [1:0] ADDR_PRESCALE = 2'd3;

    state_t           state_q, state_d;
    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             im_q, im_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_flag_q, irq_flag_d;
    logic             irq_q, irq_d;

    logic ctrl_wr;
    logic preset_wr;
    logic tick;
    logic terminal;
    logic auto_reload;

    assign ctrl_wr   = we && (addr == ADDR_CTRL);
    assign preset_wr = we && (addr == ADDR_PRESET);

`ifdef TIMER_COUNTER_PRESCALE_EN
    logic [7:0] prescale_q, prescale_d;
    logic [7:0] div_q, div_d;

    // >= rather than == so a smaller PRESCALE written mid-count cannot make the divider wrap.
    assign tick = (div_q >= prescale_q);

    always_comb begin
        prescale_d = prescale_q;
        div_d      = 8'd0;
        if (we && (addr == ADDR_PRESCALE)) begin
            prescale_d = datain[7:0];
        end
        if ((state_q == CNT) && (state_d == CNT) && !tick) begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale_q <= 8'd0;
            div_q      <= 8'd0;
        end else begin
            prescale_q <= prescale_d;
            div_q      <= div_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign terminal = tick && (count_q <= CNT_W'(1));

    // Register writes are applied first; the FSM then reacts to the post-write EN so that
    // a same-cycle disable beats a terminal tick.
    always_comb begin
        en_d        = ctrl_wr ? datain[0] : en_q;
        mode_d      = ctrl_wr ? datain[2:1] : mode_q;
        im_d        = ctrl_wr ? datain[3] : im_q;
        preset_d    = preset_wr ? datain[CNT_W-1:0] : preset_q;
        count_d     = count_q;
        state_d     = state_q;
        irq_flag_d  = irq_flag_q;
        auto_reload = (mode_d == 2'd1);

        if ((state_q != IDLE) && !en_d) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_q) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    count_d = preset_q;
                    state_d = CNT;
                end
                CNT: begin
                    if (terminal) begin
                        count_d    = '0;
                        state_d    = INT;
                        irq_flag_d = 1'b1;
                    end else if (tick) begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
                INT: begin
                    if (auto_reload) begin
                        state_d    = LOAD;
                        irq_flag_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                        if (!ctrl_wr) begin
                            en_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (ctrl_wr || preset_wr) begin
            irq_flag_d = 1'b0;
        end
        // Built from next-state values so irq tracks irq_flag & IM with no extra cycle.
        irq_d = irq_flag_d & im_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            mode_q     <= 2'd0;
            im_q       <= 1'b0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        dataout = 32'd0;
        case (addr)
            ADDR_CTRL:   dataout = {28'd0, im_q, mode_q, en_q};
            ADDR_PRESET: dataout = 32'(preset_q);
            ADDR_COUNT:  dataout = 32'(count_q);
            ADDR_PRESCALE: begin
`ifdef TIMER_COUNTER_PRESCALE_EN
                dataout = {24'd0, prescale_q};
`else
                dataout = 32'd0;
`endif
            end
            default: dataout = 32'd0;
        endcase
    end

    assign irq       = irq_q;
    assign dbg_state = state_q;

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 32: counter width, 1..32; COUNT/PRESET bits above CNT_W-1 read 0 and ignore writes.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port addr, input, 2 bits: word select; 0 CTRL, 1 PRESET, 2 COUNT, 3 PRESCALE.
REQ-005 SHALL have port we, input, 1 bit: write strobe, sampled at clk edge.
REQ-006 SHALL have port datain, input, 32 bits: write data.
REQ-007 SHALL have port dataout, output, 32 bits: combinational read of the register selected by addr.
REQ-008 SHALL have port irq, output, 1 bit: interrupt request, driven straight from a flop, feeds one hwint bit of the coprocessor.

Function
REQ-009 CTRL SHALL hold bit0 EN, bits2:1 MODE, bit3 IM; other bits read 0; MODE 2/3 behave as MODE 0.
REQ-010 COUNT SHALL be read-only; writes to addr 2 are ignored.
REQ-011 FSM SHALL have states IDLE, LOAD, CNT, INT.
REQ-012 IDLE -> LOAD when EN=1; else stay, COUNT held.
REQ-013 LOAD SHALL set COUNT=PRESET, then go to CNT; this takes 1 cycle.
REQ-014 CNT SHALL decrement COUNT by 1 on each tick (REQ-022/023); when a tick finds COUNT<=1, COUNT SHALL become 0 and the FSM SHALL go to INT.
REQ-015 PRESET=0 SHALL reach INT on the first tick in CNT, with no underflow.
REQ-016 INT, MODE 0: EN SHALL clear to 0, FSM SHALL go to IDLE, and irq_flag SHALL set and stay set until any write to CTRL or PRESET.
REQ-017 INT, MODE 1: FSM SHALL go to LOAD, and irq_flag SHALL be high for exactly the one INT cycle, giving period PRESET+2 clocks.
REQ-018 irq SHALL equal irq_flag AND IM, registered.
REQ-019 In any state other than IDLE, EN=0 (by write) SHALL move the FSM to IDLE on the next edge, with COUNT held; a later EN=1 re-enters via LOAD.
REQ-020 A register write SHALL win over an FSM update in the same cycle; a CTRL write clearing EN in the same cycle as a terminal tick SHALL give IDLE, with no irq_flag set.
REQ-021 A PRESET write during CNT SHALL NOT alter the current COUNT; it is used at the next LOAD.

Reset
REQ-024 While reset=0, regardless of clk: CTRL=0, PRESET=0, COUNT=0, PRESCALE=0, irq_flag=0, irq=0, FSM=IDLE.
REQ-025 Reset asserted mid-count SHALL abort immediately with no irq pulse; after release the block SHALL stay in IDLE until EN is written.
REQ-026 dataout after reset SHALL read 0 at every addr.

Configuration
REQ-022 With TIMER_COUNTER_PRESCALE_EN defined: PRESCALE[7:0] is read/write at addr 3, an 8-bit divider yields a tick every PRESCALE+1 clocks in CNT, and the divider clears on LOAD and on leaving CNT.
REQ-023 Without TIMER_COUNTER_PRESCALE_EN: addr 3 reads 0, writes are ignored, every clock in CNT is a tick, and no divider logic is instantiated.

Verification
REQ-027 Scenario, MODE 0 one-shot: PRESET=5, CTRL=0x9 -> COUNT reads 5,4,3,2,1,0; irq rises 7 cycles after EN write and holds; a CTRL write of 0x8 drops irq next cycle.
REQ-028 Scenario, MODE 1 auto-reload: PRESET=3, CTRL=0xB -> irq 1-cycle pulse every 5 clocks, 4 pulses in 20 cycles; EN stays 1.
REQ-029 Scenario, IM masked: PRESET=2, CTRL=0x1 -> irq stays 0, EN clears after terminal, COUNT=0; a subsequent CTRL=0x8 write leaves irq=0 because the flag is cleared.
REQ-030 Scenario, disable and PRESET=0 edge: PRESET=0, CTRL=0x9 -> irq after 3 cycles. Then PRESET=10, CTRL=0x9, and CTRL=0 written when COUNT=4 -> COUNT holds 4, no irq, FSM IDLE.
REQ-031 Scenario, reset mid-count and same-cycle write: reset=0 at COUNT=3 -> all registers 0 at once, irq=0. Then a CTRL=0 write in the terminal-tick cycle -> no irq.
REQ-032 Scenario, prescaler, only with TIMER_COUNTER_PRESCALE_EN: PRESCALE=3, PRESET=2, CTRL=0x9 -> COUNT decrements every 4 clocks; irq after 1+1+8 cycles.
